// File: rtl/dmtd_phase_ctrl_pkg.sv
// ============================================================
// dmtd_phase_ctrl_pkg : shared constants and FSM state encoding
// Rev 1.0
// ============================================================
`default_nettype none

package dmtd_phase_ctrl_pkg;

  localparam int CNT_W_DEF    = 24;
  localparam int DEGLITCH_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARM    = 3'd1;
  localparam state_t ST_MEAS_B = 3'd2;
  localparam state_t ST_MEAS_A = 3'd3;
  localparam state_t ST_REPORT = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dmtd_deglitch.sv
// ============================================================
// dmtd_deglitch : consecutive-sample level filter with rise pulse
// Rev 1.0
// ============================================================
`default_nettype none

module dmtd_deglitch
  import dmtd_phase_ctrl_pkg::*;
#(
  parameter int DEGLITCH = DEGLITCH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [3:0] LAST = 4'(DEGLITCH - 1);

  logic [3:0] cnt;

  // rise is registered with level so both channels see identical latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      rise <= 1'b0;
      if (din != level) begin
        if (cnt == LAST) begin
          level <= din;
          rise  <= din;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmtd_phase_ctrl.sv
// ============================================================
// dmtd_phase_ctrl : DMTD beat phase/period measurement sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module dmtd_phase_ctrl
  import dmtd_phase_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEGLITCH = DEGLITCH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_a,
  input  logic             beat_b,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       n_meas,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_phase,
  output logic [CNT_W-1:0] res_period,
  output logic             res_timeout,
  output logic             res_last
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       raw;
  logic [1:0]       level;
  logic [1:0]       rise;
  logic             a_rise;
  logic             b_rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       remaining;
  logic             unused_levels;

  assign raw = {beat_b, beat_a};

  for (genvar i = 0; i < 2; i++) begin : g_beat
    dmtd_deglitch #(.DEGLITCH(DEGLITCH)) u_deglitch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  assign a_rise        = rise[0];
  assign b_rise        = rise[1];
  // filtered levels are not needed here, only their rising events
  assign unused_levels = &{1'b0, level};

  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      remaining   <= 8'd0;
      res_phase   <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
      res_last    <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && n_meas != 8'd0) begin
            state     <= ST_ARM;
            cnt       <= '0;
            remaining <= n_meas;
          end
        end
        ST_ARM: begin
          cnt <= cnt + CNT_ONE;
          if (a_rise) begin
            cnt <= CNT_ONE;
            if (b_rise) begin
              res_phase <= '0;
              state     <= ST_MEAS_A;
            end else begin
              state <= ST_MEAS_B;
            end
          end else if (cnt == CNT_MAX) begin
            res_phase   <= '1;
            res_period  <= '1;
            res_timeout <= 1'b1;
            res_last    <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_MEAS_B: begin
          cnt <= cnt + CNT_ONE;
          if (b_rise) begin
            res_phase <= cnt;
            if (a_rise) begin
              // B coincides with the next A: phase equals a full period
              res_period  <= cnt;
              res_timeout <= 1'b0;
              res_last    <= (remaining == 8'd1);
              state       <= ST_REPORT;
            end else begin
              state <= ST_MEAS_A;
            end
          end else if (cnt == CNT_MAX) begin
            res_phase   <= '1;
            res_period  <= '1;
            res_timeout <= 1'b1;
            res_last    <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_MEAS_A: begin
          cnt <= cnt + CNT_ONE;
          if (a_rise) begin
            res_period  <= cnt;
            res_timeout <= 1'b0;
            res_last    <= (remaining == 8'd1);
            state       <= ST_REPORT;
          end else if (cnt == CNT_MAX) begin
            res_period  <= '1;
            res_timeout <= 1'b1;
            res_last    <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1 || res_timeout) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_ARM;
              cnt   <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmtd_phase_ctrl.sv
// ============================================================
// tb_dmtd_phase_ctrl : table-driven bench, DEGLITCH=2 and =4 in lockstep
// Rev 1.0
// ============================================================
`default_nettype none

module tb_dmtd_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       beat_a = 1'b0;
  logic       beat_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] n_meas = 8'd0;
  logic       res_ready = 1'b0;

  logic       busy_2, valid_2, timeout_2, last_2;
  logic [7:0] phase_2, period_2;
  logic       busy_4, valid_4, timeout_4, last_4;
  logic [7:0] phase_4, period_4;

  int errors = 0;
  int checks = 0;

  dmtd_phase_ctrl #(.CNT_W(8), .DEGLITCH(2)) dut_2 (
    .clk(clk), .rst_n(rst_n), .beat_a(beat_a), .beat_b(beat_b),
    .start(start), .abort(abort), .n_meas(n_meas), .busy(busy_2),
    .res_valid(valid_2), .res_ready(res_ready), .res_phase(phase_2),
    .res_period(period_2), .res_timeout(timeout_2), .res_last(last_2)
  );

  dmtd_phase_ctrl #(.CNT_W(8), .DEGLITCH(4)) dut_4 (
    .clk(clk), .rst_n(rst_n), .beat_a(beat_a), .beat_b(beat_b),
    .start(start), .abort(abort), .n_meas(n_meas), .busy(busy_4),
    .res_valid(valid_4), .res_ready(res_ready), .res_phase(phase_4),
    .res_period(period_4), .res_timeout(timeout_4), .res_last(last_4)
  );

  always #5 clk = ~clk;

  // Beat generator: A rises at t%100==0, B is A delayed by d, plus an
  // optional glitch of glen cycles starting 10 cycles after the A edge.
  int t = 0;
  int d = 30;
  int glen = 0;
  bit a_on = 1'b1;
  int pa, pb;

  always @(negedge clk) begin
    t = t + 1;
    pa = t % 100;
    pb = (t + 100 - d) % 100;
    beat_a = a_on && (pa < 50);
    beat_b = (pb < 50) || (glen > 0 && pa >= 10 && pa < 10 + glen);
  end

  typedef struct {
    int d;
    int glen;
    int ph2;
    int ph4;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    n_meas = 8'(n);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic wait_both(input int lim, output int n);
    n = 0;
    while (!(valid_2 && valid_4) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", int'(valid_2 && valid_4), 1);
  endtask

  int n;
  int bad;

  initial begin
    vecs[0] = '{d: 30, glen: 0, ph2: 30, ph4: 30};
    vecs[1] = '{d: 0,  glen: 0, ph2: 0,  ph4: 0};
    vecs[2] = '{d: 70, glen: 0, ph2: 70, ph4: 70};
    vecs[3] = '{d: 99, glen: 0, ph2: 99, ph4: 99};
    vecs[4] = '{d: 30, glen: 1, ph2: 30, ph4: 30};
    vecs[5] = '{d: 30, glen: 2, ph2: 10, ph4: 30};
    vecs[6] = '{d: 30, glen: 4, ph2: 10, ph4: 10};

    repeat (5) @(negedge clk);
    chk("rst_busy",    int'(busy_2 | busy_4), 0);
    chk("rst_valid",   int'(valid_2 | valid_4), 0);
    chk("rst_phase",   int'(phase_2 | phase_4), 0);
    chk("rst_period",  int'(period_2 | period_4), 0);
    chk("rst_flags",   int'({timeout_2, last_2, timeout_4, last_4}), 0);
    rst_n = 1'b1;

    pulse_start(0);
    chk("start_n0_ignored", int'(busy_2 | busy_4), 0);

    for (int i = 0; i < 7; i++) begin
      d = vecs[i].d;
      glen = vecs[i].glen;
      a_on = 1'b1;
      repeat (200) @(negedge clk);
      pulse_start(1);
      chk("busy_after_start", int'(busy_2 & busy_4), 1);
      wait_both(400, n);
      chk($sformatf("v%0d_phase_dg2", i), int'(phase_2), vecs[i].ph2);
      chk($sformatf("v%0d_phase_dg4", i), int'(phase_4), vecs[i].ph4);
      chk($sformatf("v%0d_period_dg2", i), int'(period_2), 100);
      chk($sformatf("v%0d_period_dg4", i), int'(period_4), 100);
      chk($sformatf("v%0d_timeout", i), int'(timeout_2 | timeout_4), 0);
      chk($sformatf("v%0d_last", i), int'(last_2 & last_4), 1);
      handshake();
      chk($sformatf("v%0d_idle_after", i), int'(busy_2 | busy_4 | valid_2 | valid_4), 0);
    end

    // Timeout with n_meas=2: last forced, sequence ends after handshake
    glen = 0;
    a_on = 1'b0;
    repeat (10) @(negedge clk);
    pulse_start(2);
    wait_both(400, n);
    chk("to_latency_in_range", int'(n >= 255 && n <= 257), 1);
    chk("to_timeout", int'(timeout_2 & timeout_4), 1);
    chk("to_phase",   int'(phase_2), 255);
    chk("to_period",  int'(period_4), 255);
    chk("to_last",    int'(last_2 & last_4), 1);
    handshake();
    chk("to_idle_after", int'(busy_2 | busy_4), 0);

    // Three results with a 50-cycle stall on each
    a_on = 1'b1;
    d = 30;
    repeat (150) @(negedge clk);
    pulse_start(3);
    for (int i = 0; i < 3; i++) begin
      wait_both(400, n);
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (!valid_2 || !valid_4 || phase_2 != 8'd30 || phase_4 != 8'd30 ||
            period_2 != 8'd100 || period_4 != 8'd100 ||
            last_2 != (i == 2) || last_4 != (i == 2))
          bad++;
      end
      chk($sformatf("stall%0d_stable", i), bad, 0);
      chk($sformatf("stall%0d_last", i), int'(last_2), (i == 2) ? 1 : 0);
      handshake();
      chk($sformatf("stall%0d_busy", i), int'(busy_2 & busy_4), (i < 2) ? 1 : 0);
    end

    // Reset pulse during MEAS_A
    while (t % 100 != 50) @(negedge clk);
    pulse_start(1);
    repeat (98) @(negedge clk);
    chk("pre_rst_busy", int'(busy_2 & busy_4), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_valid", int'(busy_2 | busy_4 | valid_2 | valid_4), 0);
    chk("mid_rst_data", int'(phase_2 | period_2 | phase_4 | period_4), 0);
    chk("mid_rst_flags", int'({timeout_2, last_2, timeout_4, last_4}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid_2 || valid_4 || busy_2 || busy_4) bad++;
    end
    chk("post_rst_silent", bad, 0);

    // Abort in REPORT beats a same-cycle handshake
    pulse_start(2);
    wait_both(400, n);
    @(negedge clk);
    abort = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    res_ready = 1'b0;
    chk("abort_busy", int'(busy_2 | busy_4), 0);
    chk("abort_valid", int'(valid_2 | valid_4), 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid_2 || valid_4 || busy_2 || busy_4) bad++;
    end
    chk("post_abort_silent", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
